keypad_scanner: RTL

- Input-side counterpart of the multiplexed 7-segment driver.
- Scans a 4x4 hex keypad by driving one active-low column strobe at a time, reads the active-low rows, and debounces the result.
- Emits a 4-bit hex key code plus a one-cycle valid pulse; the code feeds the display's digit inputs and the CPU's input logic.
- Column strobe order and timing mirror the display's digit-enable rotation: 0111 -> 1011 -> 1101 -> 1110.

---
 rtl/keypad_scanner_pkg.sv | 46 ++++
 rtl/keypad_row_sync.sv | 27 ++
 rtl/keypad_scanner.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared state encoding, strobe constants and small helpers for the 4x4 keypad scanner.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_e;

    localparam int KEY_W = 4;

    localparam logic [3:0] COL3     = 4'b0111;
    localparam logic [3:0] COL2     = 4'b1011;
    localparam logic [3:0] COL1     = 4'b1101;
    localparam logic [3:0] COL0     = 4'b1110;
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Rotation mirrors the display's digit-enable order.
    function automatic logic [3:0] next_col(input logic [3:0] col);
        logic [3:0] nxt;
        case (col)
            COL3:    nxt = COL2;
            COL2:    nxt = COL1;
            COL1:    nxt = COL0;
            default: nxt = COL3;
        endcase
        return nxt;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // True when exactly one bit is low; ghosts (several lows) count as no key.
    function automatic logic single_low(input logic [3:0] v);
        logic [3:0] lows;
        lows = ~v;
        return (v != ROW_IDLE) && ((lows & (lows - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows; idles high (no key).
module keypad_row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages sample the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounce; optional digit shift register under KEYPAD_DIGIT_SHIFT_EN.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_TICKS     = 3000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
`ifdef KEYPAD_DIGIT_SHIFT_EN
    ,
    output logic [KEY_W-1:0] digit_0,
    output logic [KEY_W-1:0] digit_1,
    output logic [KEY_W-1:0] digit_2,
    output logic [KEY_W-1:0] digit_3
`endif
);

    localparam logic [13:0] TICK_LAST  = 14'(SCAN_TICKS - 1);
    localparam logic [3:0]  DEB_TARGET = 4'(DEBOUNCE_SCANS);

    state_e           state_q, state_d;
    logic [13:0]      tick_q;
    logic [3:0]       col_q, col_d;
    logic [3:0]       deb_q, deb_d;
    logic [3:0]       lat_row_q, lat_row_d;
    logic [1:0]       lat_r_q, lat_r_d;
    logic [KEY_W-1:0] key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic [3:0] srow;
    logic       sample;
    logic       single;
    logic       accept;

    keypad_row_sync #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (row),
        .q_o   (srow)
    );

    assign sample = (tick_q == TICK_LAST);
    assign single = single_low(srow);
    assign accept = (state_q != PRESSED) && (state_d == PRESSED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            tick_q      <= '0;
            col_q       <= COL3;
            deb_q       <= '0;
            lat_row_q   <= ROW_IDLE;
            lat_r_q     <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= sample ? '0 : tick_q + 14'd1;
            col_q       <= col_d;
            deb_q       <= deb_d;
            lat_row_q   <= lat_row_d;
            lat_r_q     <= lat_r_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (sample) begin
            case (state_q)
                SCAN:     if (single) state_d = (DEBOUNCE_SCANS == 1) ? PRESSED : DEBOUNCE;
                DEBOUNCE: begin
                    if (srow != lat_row_q)                  state_d = SCAN;
                    else if (deb_q + 4'd1 == DEB_TARGET)    state_d = PRESSED;
                end
                PRESSED:  if (srow[lat_r_q] && (deb_q + 4'd1 == DEB_TARGET)) state_d = SCAN;
                default:  state_d = SCAN;
            endcase
        end
    end

    always_comb begin
        col_d       = col_q;
        deb_d       = deb_q;
        lat_row_d   = lat_row_q;
        lat_r_d     = lat_r_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (single) begin
                        lat_row_d = srow;
                        lat_r_d   = low_index(srow);
                        deb_d     = 4'd1;
                    end else begin
                        col_d = next_col(col_q);
                    end
                end
                DEBOUNCE: begin
                    if (srow == lat_row_q) begin
                        deb_d = deb_q + 4'd1;
                    end else begin
                        deb_d = '0;
                        col_d = next_col(col_q);
                    end
                end
                PRESSED: begin
                    if (!srow[lat_r_q]) begin
                        deb_d = '0;
                    end else if (state_d == SCAN) begin
                        deb_d      = '0;
                        key_held_d = 1'b0;
                        col_d      = next_col(col_q);
                    end else begin
                        deb_d = deb_q + 4'd1;
                    end
                end
                default: deb_d = '0;
            endcase
            // The release counter reuses deb_q, so it restarts from zero on acceptance.
            if (accept) begin
                key_code_d  = {lat_r_d, low_index(col_q)};
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
                deb_d       = '0;
            end
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

`ifdef KEYPAD_DIGIT_SHIFT_EN
    logic [KEY_W-1:0] digit_0_q, digit_1_q, digit_2_q, digit_3_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_0_q <= '0;
            digit_1_q <= '0;
            digit_2_q <= '0;
            digit_3_q <= '0;
        end else if (key_valid_q) begin
            digit_3_q <= digit_2_q;
            digit_2_q <= digit_1_q;
            digit_1_q <= digit_0_q;
            digit_0_q <= key_code_q;
        end
    end

    assign digit_0 = digit_0_q;
    assign digit_1 = digit_1_q;
    assign digit_2 = digit_2_q;
    assign digit_3 = digit_3_q;
`endif

endmodule
